// File: rtl/wb_scoreboard_if.sv
// Issue/writeback bundle between the decode stage and the writeback scoreboard.
// The master side presents instructions; the slave side answers with hazard and writeback state.
interface wb_scoreboard_if #(
  parameter int NUM_FU = 5,
  parameter int FU_W   = $clog2(NUM_FU)
);
  logic              issue_valid;
  logic [FU_W-1:0]   issue_fu;
  logic [4:0]        issue_rd;
  logic [4:0]        issue_rs1;
  logic [4:0]        issue_rs2;
  logic              issue_rd_used;
  logic              issue_rs1_used;
  logic              issue_rs2_used;
  logic              flush;
  logic              issue_ready;
  logic              issue_fire;
  logic [NUM_FU-1:0] fu_busy;
  logic [31:0]       pending;
  logic              wb_valid;
  logic [FU_W-1:0]   wb_fu;
  logic [4:0]        wb_rd;

  modport master (
    output issue_valid, issue_fu, issue_rd, issue_rs1, issue_rs2,
           issue_rd_used, issue_rs1_used, issue_rs2_used, flush,
    input  issue_ready, issue_fire, fu_busy, pending, wb_valid, wb_fu, wb_rd
  );

  modport slave (
    input  issue_valid, issue_fu, issue_rd, issue_rs1, issue_rs2,
           issue_rd_used, issue_rs1_used, issue_rs2_used, flush,
    output issue_ready, issue_fire, fu_busy, pending, wb_valid, wb_fu, wb_rd
  );
endinterface

// File: rtl/wb_scoreboard.sv
// In-order issue scoreboard: RAW/WAW/FU-busy/writeback-port gating with an
// exact-cycle writeback slot shift register driving the single register-file write port.
module wb_scoreboard #(
  parameter int                    NUM_FU       = 5,
  parameter int                    FU_W         = $clog2(NUM_FU),
  parameter int                    LAT_W        = 5,
  parameter logic [NUM_FU*LAT_W-1:0] FU_LAT     = {5'd2, 5'd24, 5'd7, 5'd2, 5'd1},
  parameter logic [NUM_FU-1:0]     FU_PIPELINED = 5'b00101,
  parameter int                    SLOT_DEPTH   = 32
) (
  input logic            clk,
  input logic            rst,
  wb_scoreboard_if.slave sb
);

  logic [LAT_W-1:0]      lat_tab      [NUM_FU];
  logic [LAT_W-1:0]      busy_cnt_reg [NUM_FU];
  logic [SLOT_DEPTH-1:0] slot_v_reg, slot_v_next;
  logic [FU_W-1:0]       slot_fu_reg  [SLOT_DEPTH];
  logic [FU_W-1:0]       slot_fu_next [SLOT_DEPTH];
  logic [4:0]            slot_rd_reg  [SLOT_DEPTH];
  logic [4:0]            slot_rd_next [SLOT_DEPTH];
  logic [31:0]           pending_reg, pending_next;
  logic [LAT_W-1:0]      issue_lat;
  logic                  fu_ok, sel_busy, port_hit, raw_hit, waw_hit;
  logic                  ready_c, fire_c;

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
      assign lat_tab[gi]    = FU_LAT[gi*LAT_W +: LAT_W];
      assign sb.fu_busy[gi] = (busy_cnt_reg[gi] != '0);

      // Pipelined units are never loaded, so their counter stays at zero.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          busy_cnt_reg[gi] <= '0;
        end else if (fire_c && (sb.issue_fu == FU_W'(gi)) && !FU_PIPELINED[gi]) begin
          busy_cnt_reg[gi] <= lat_tab[gi] - LAT_W'(1);
        end else if (busy_cnt_reg[gi] != '0) begin
          busy_cnt_reg[gi] <= busy_cnt_reg[gi] - LAT_W'(1);
        end
      end
    end
  endgenerate

  always_comb begin
    fu_ok     = ({1'b0, sb.issue_fu} < (FU_W+1)'(NUM_FU));
    issue_lat = '0;
    sel_busy  = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (sb.issue_fu == FU_W'(i)) begin
        issue_lat = lat_tab[i];
        sel_busy  = (busy_cnt_reg[i] != '0);
      end
    end
    // Slot L would shift into L-1 this edge; index SLOT_DEPTH is beyond the array and always empty.
    port_hit = 1'b0;
    for (int k = 1; k < SLOT_DEPTH; k++) begin
      if (int'(issue_lat) == k) port_hit = slot_v_reg[k];
    end
    raw_hit = (sb.issue_rs1_used & pending_reg[sb.issue_rs1]) |
              (sb.issue_rs2_used & pending_reg[sb.issue_rs2]);
    waw_hit = sb.issue_rd_used & pending_reg[sb.issue_rd];
    ready_c = fu_ok & ~sel_busy & ~port_hit & ~raw_hit & ~waw_hit;
    fire_c  = sb.issue_valid & ready_c & ~sb.flush;
  end

  always_comb begin
    for (int k = 0; k < SLOT_DEPTH - 1; k++) begin
      slot_v_next[k]  = slot_v_reg[k+1];
      slot_fu_next[k] = slot_fu_reg[k+1];
      slot_rd_next[k] = slot_rd_reg[k+1];
    end
    slot_v_next[SLOT_DEPTH-1]  = 1'b0;
    slot_fu_next[SLOT_DEPTH-1] = '0;
    slot_rd_next[SLOT_DEPTH-1] = '0;
    // Ops without a destination still take a slot so their completion is reported.
    if (fire_c) begin
      for (int k = 0; k < SLOT_DEPTH; k++) begin
        if (int'(issue_lat) - 1 == k) begin
          slot_v_next[k]  = 1'b1;
          slot_fu_next[k] = sb.issue_fu;
          slot_rd_next[k] = sb.issue_rd_used ? sb.issue_rd : 5'd0;
        end
      end
    end
  end

  always_comb begin
    pending_next = pending_reg;
    if (slot_v_reg[0]) pending_next[slot_rd_reg[0]] = 1'b0;
    if (fire_c && sb.issue_rd_used && (sb.issue_rd != 5'd0)) pending_next[sb.issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v_reg  <= '0;
      pending_reg <= '0;
      for (int k = 0; k < SLOT_DEPTH; k++) begin
        slot_fu_reg[k] <= '0;
        slot_rd_reg[k] <= '0;
      end
    end else begin
      slot_v_reg  <= slot_v_next;
      pending_reg <= pending_next;
      for (int k = 0; k < SLOT_DEPTH; k++) begin
        slot_fu_reg[k] <= slot_fu_next[k];
        slot_rd_reg[k] <= slot_rd_next[k];
      end
    end
  end

  assign sb.issue_ready = ready_c;
  assign sb.issue_fire  = fire_c;
  assign sb.pending     = pending_reg;
  assign sb.wb_valid    = slot_v_reg[0];
  assign sb.wb_fu       = slot_fu_reg[0];
  assign sb.wb_rd       = slot_rd_reg[0];

endmodule
